// File: rtl/cla_serial_add_ctrl.sv
// Serial add/subtract controller: one 4-bit carry-lookahead slice reused per nibble, LSB first.
// The nibble carry is registered between passes; the result is assembled in sum_q.
//
//   state  | meaning
//   IDLE   | ready for a request; operands latched on accept
//   RUN    | one nibble per cycle through the slice, carry chained in carry_q
//   DONE   | result valid and held until res_ready
module cla_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / 4;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NW-1:0]    nib_q, nib_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] sl_a, sl_b, sl_g, sl_p, sl_s;
  logic [4:0] sl_c;

  always_comb begin
    sl_a    = a_q[{nib_q, 2'b00} +: 4];
    sl_b    = b_q[{nib_q, 2'b00} +: 4];
    sl_g    = sl_a & sl_b;
    sl_p    = sl_a | sl_b;
    sl_c[0] = carry_q;
    sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
    sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_s    = sl_a ^ sl_b ^ sl_c[3:0];
  end

  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          a_d     = a_in;
          b_d     = sub ? ~b_in : b_in;
          carry_d = sub ? 1'b1 : cin;
          nib_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[{nib_q, 2'b00} +: 4] = sl_s;
        carry_d = sl_c[4];
        nib_d   = nib_q + NW'(1);
        if (nib_q == NW'(N - 1)) begin
          cout_d  = sl_c[4];
          // Overflow: carry into the sign bit differs from carry out of it.
          ovf_d   = sl_c[3] ^ sl_c[4];
          nib_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      nib_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign res_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed bench for cla_serial_add_ctrl (WIDTH=16): hand-computed vectors,
// immediate assertions, inputs driven and outputs sampled on the falling edge.
module tb_cla_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a_in, b_in;
  logic        cin, sub;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] sum;
  logic        cout, ovf, busy;

  int n_vec = 0;
  int n_err = 0;

  cla_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin), .sub(sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, expect res_valid after exactly 4 edges, check result, then handshake.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s,
                        input logic [15:0] e_sum, input logic e_cout, input logic e_ovf);
    int lat;
    @(negedge clk);
    start_valid = 1'b1; a_in = a; b_in = b; cin = c; sub = s;
    @(negedge clk);
    start_valid = 1'b0; a_in = 16'hDEAD; b_in = 16'hBEEF; cin = 1'b0; sub = 1'b0;
    check({tag, ".busy_after_accept"}, {31'd0, busy}, 32'd1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, ".latency"}, lat, 32'd4);
    check({tag, ".sum"}, {16'd0, sum}, {16'd0, e_sum});
    check({tag, ".cout"}, {31'd0, cout}, {31'd0, e_cout});
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, ".idle_after_hs"}, {30'd0, res_valid, start_ready}, 32'd1);
    check({tag, ".sum_held"}, {16'd0, sum}, {16'd0, e_sum});
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; a_in = '0; b_in = '0;
    cin = 1'b0; sub = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset.ctrl", {29'd0, start_ready, res_valid, busy}, 32'b100);
    check("reset.result", {14'd0, sum, cout, ovf}, 32'd0);

    run_op("add_basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple_b1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ripple_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_pos",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_neg",     16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_noborr",  16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure: result must hold and new requests must be refused.
    @(negedge clk);
    start_valid = 1'b1; a_in = 16'h00F0; b_in = 16'h0F10; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("bp.valid", {31'd0, res_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      start_valid = (i == 2);
      a_in = 16'h0001; b_in = 16'h0001;
      @(negedge clk);
      check($sformatf("bp.hold%0d", i),
            {12'd0, sum, cout, ovf, res_valid, start_ready},
            {12'd0, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b0});
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp.after_hs", {29'd0, res_valid, start_ready, busy}, 32'b010);
    @(negedge clk);
    check("bp.no_queue", {31'd0, busy}, 32'd0);
    run_op("bp.next", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

    // Reset after two nibbles of a full carry ripple.
    @(negedge clk);
    start_valid = 1'b1; a_in = 16'hFFFF; b_in = 16'h0001; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid.ctrl", {29'd0, start_ready, res_valid, busy}, 32'b100);
    check("rst_mid.result", {14'd0, sum, cout, ovf}, 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (res_valid) seen++;
      end
      check("rst_mid.no_valid", seen, 32'd0);
    end
    run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
